fir_sample_window: RTL
======================

Name: fir_sample_window

Overview:
Upstream stage of the highpass FIR. It converts a serial stream of 16-bit two's-complement samples into the 240-bit, 15-slot parallel window that the filter consumes. It also tracks how many valid samples have entered for the currently selected tap setting, and flags when the window is fully primed. The filter's tap input and this block's tap input are driven from the same source.

Parameters:
SAMPLE_W, 16, bits per sample (Q6.10 two's complement)
MAX_SLOTS, 15, number of window slots; window width = SAMPLE_W*MAX_SLOTS

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of window and fill state
tap  in  4  tap selection, identical encoding to the filter
in_valid  in  1  in_sample is accepted this cycle; the block is always ready, with no backpressure
in_sample  in  SAMPLE_W  new sample
window  out  SAMPLE_W*MAX_SLOTS  slot i = window[16i+15:16i]; slot 0 holds the newest sample
window_strobe  out  1  one-cycle pulse: window updated and primed
window_primed  out  1  level: required sample count reached for the current tap
fill_count  out  4  samples counted since the last clear, saturating

Behaviour:
- Reset (rst_n low, async): all slots 0, fill_count 0, window_primed 0, window_strobe 0, state IDLE.
- Required length: need(tap) = 2*floor(tap/2)+1.
  - tap 1 → 1; tap 2,3 → 3; tap 4,5 → 5; … tap 14,15 → 15.
  - tap 0 → need = 0, and the block stays in IDLE.
- Shift on accept (in_valid=1, flush=0):
  - slot[i] <= slot[i-1] for i = 1..14; slot[0] <= in_sample.
  - The oldest sample is discarded.
  - Registered: the window is visible the cycle after in_valid.
- fill_count increments on accept and saturates at need(tap).
- FSM states: IDLE, FILL, RUN.
  - IDLE: tap==0. Samples still shift, but fill_count is held at 0 and both primed and strobe are 0. When tap≠0, go to FILL.
  - FILL: on an accept that makes fill_count reach need, go to RUN. In that same registered update, window_primed goes to 1 and window_strobe pulses.
  - RUN: every accept pulses window_strobe one cycle after in_valid. window_primed stays 1.
- Tap change: tap is sampled into tap_q every cycle. When tap != tap_q:
  - fill_count clears to 0, window_primed drops next cycle, and the next state is FILL (or IDLE if the new tap is 0).
  - Window contents are retained.
  - If an accept occurs in the same cycle, that sample is shifted in and fill_count becomes 1. If need is 1, the block goes directly to RUN.
- flush: all slots, fill_count, primed and strobe clear next cycle; next state is IDLE or FILL according to tap. flush wins over a simultaneous in_valid, and that sample is dropped.
- Reset mid-stream: immediate async clear; no partial window is ever flagged primed.
- in_valid=0: window, fill_count and state hold; strobe is 0.
- No arithmetic is performed on samples; the data path is a pure register shift.

Optional Feature:
WINDOW_ZERO_PAD_EN
- Defined: slots with index ≥ need(tap) are presented as 0 on the window output. The internal registers still shift. tap=0 presents an all-zero window.
- Undefined: all 15 slots are presented raw.

Decomposition:
- Shared package fir_pkg:
  - SAMPLE_W and MAX_SLOTS localparams.
  - WIN_W = SAMPLE_W*MAX_SLOTS.
  - Sample and window typedefs.
  - Function tap_to_len(tap) returning need. The filter and the bench reuse this function.
- Sub-module fir_window_ctrl: FSM, tap_q, fill_count, primed/strobe generation.
- The top level holds only the slot shift register and the optional zero-pad mask.

Test Plan:
- Reset then prime: tap=3; accept 0x0001, 0x0002, 0x0003 on consecutive cycles.
  - One cycle after the third accept: window[47:0]=48'h0001_0002_0003, fill_count=3, primed=1, one strobe pulse.
  - No strobe after the first or second accept.
- Full window: tap=15; accept 0x0010..0x001E.
  - Primed after the 15th accept; slot0=0x001E, slot14=0x0010.
  - A 16th accept of 0x001F gives slot14=0x0011, with a strobe.
- Tap change mid-RUN: primed with tap=5; set tap=2 together with an accept of 0xFFC0.
  - Next cycle: primed=0, fill_count=1.
  - Two more accepts → primed=1; the window contents were never cleared.
- flush vs in_valid: in RUN, assert flush and in_valid with 0x1234 together.
  - Next cycle: window all 0, fill_count=0, primed=0, and 0x1234 is absent.
- Async reset mid-FILL: drop rst_n between clock edges → all outputs are 0 immediately.
- tap=0 and zero pad: tap=0 with accepts → primed and strobe stay 0, fill_count=0.
  - With WINDOW_ZERO_PAD_EN defined: window=0.
  - With tap=1: only slot0 is non-zero.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the highpass FIR: sample/window types and the tap-to-length map.
package fir_pkg;
  localparam int SAMPLE_W  = 16;
  localparam int MAX_SLOTS = 15;
  localparam int WIN_W     = SAMPLE_W * MAX_SLOTS;

  typedef logic [SAMPLE_W-1:0]                 sample_t;
  typedef logic [MAX_SLOTS-1:0][SAMPLE_W-1:0]  window_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN
  } win_state_e;

  // Odd window length for a tap setting: 2*floor(tap/2)+1, or 0 when the filter is off.
  function automatic logic [3:0] tap_to_len(input logic [3:0] tap);
    return (tap == 4'd0) ? 4'd0 : {tap[3:1], 1'b1};
  endfunction
endpackage

// File: rtl/fir_window_ctrl.sv
// Fill tracking for the sample window: IDLE/FILL/RUN FSM, tap change detection,
// saturating fill counter and the primed level / strobe pulse.
module fir_window_ctrl
  import fir_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic [3:0] tap,
  input  logic       in_valid,
  output logic       window_strobe,
  output logic       window_primed,
  output logic [3:0] fill_count
);

  win_state_e state_q, state_d;
  logic [3:0] tap_q, tap_d;
  logic [3:0] fill_q, fill_d;
  logic       primed_q, primed_d;
  logic       strobe_q, strobe_d;

  logic [3:0] need;
  logic       accept;
  logic       tap_chg;

  assign need    = tap_to_len(tap);
  assign accept  = in_valid & ~flush;
  assign tap_chg = (tap != tap_q);

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    primed_d = primed_q;
    strobe_d = 1'b0;
    tap_d    = tap;
    if (flush) begin
      fill_d   = 4'd0;
      primed_d = 1'b0;
      state_d  = (tap == 4'd0) ? ST_IDLE : ST_FILL;
    end else if (tap == 4'd0) begin
      fill_d   = 4'd0;
      primed_d = 1'b0;
      state_d  = ST_IDLE;
    end else if (tap_chg || state_q == ST_IDLE) begin
      // Restart counting; a same-cycle accept is the first sample of the new setting.
      fill_d   = 4'd0;
      primed_d = 1'b0;
      state_d  = ST_FILL;
      if (accept) begin
        fill_d = 4'd1;
        if (need == 4'd1) begin
          state_d  = ST_RUN;
          primed_d = 1'b1;
          strobe_d = 1'b1;
        end
      end
    end else if (accept) begin
      fill_d = (fill_q >= need) ? need : fill_q + 4'd1;
      if (fill_d == need) begin
        state_d  = ST_RUN;
        primed_d = 1'b1;
        strobe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tap_q    <= 4'd0;
      fill_q   <= 4'd0;
      primed_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      fill_q   <= fill_d;
      primed_q <= primed_d;
      strobe_q <= strobe_d;
    end
  end

  assign window_strobe = strobe_q;
  assign window_primed = primed_q;
  assign fill_count    = fill_q;

endmodule

// File: rtl/fir_sample_window.sv
// Serial-to-parallel sample window feeding the highpass FIR (slot 0 = newest).
// Optional WINDOW_ZERO_PAD_EN: slots at or beyond the current window length read as 0.
module fir_sample_window
  import fir_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [3:0]          tap,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_sample,
  output logic [WIN_W-1:0]    window,
  output logic                window_strobe,
  output logic                window_primed,
  output logic [3:0]          fill_count
);

  window_t window_q, window_d;

  // Flush beats a simultaneous sample, which is dropped.
  always_comb begin
    window_d = window_q;
    if (flush)
      window_d = '0;
    else if (in_valid)
      window_d = {window_q[MAX_SLOTS-2:0], in_sample};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) window_q <= '0;
    else        window_q <= window_d;
  end

`ifdef WINDOW_ZERO_PAD_EN
  logic [3:0] need;
  assign need = tap_to_len(tap);

  for (genvar g = 0; g < MAX_SLOTS; g++) begin : g_pad
    assign window[g*SAMPLE_W +: SAMPLE_W] = (4'(g) < need) ? window_q[g] : '0;
  end
`else
  assign window = window_q;
`endif

  fir_window_ctrl u_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .tap           (tap),
    .in_valid      (in_valid),
    .window_strobe (window_strobe),
    .window_primed (window_primed),
    .fill_count    (fill_count)
  );

endmodule
